// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// dac_pkg : shared widths, envelope/code limits and ramp state encoding
// Revision: 1.0
// ============================================================================
package dac_pkg;

    localparam int IN_W      = 19;
    localparam int OUT_W     = 14;
    localparam int GAIN_FRAC = 14;
    localparam int ENV_FRAC  = 15;

    localparam logic [16:0] ENV_ONE = 17'd32768;
    localparam int          DAC_MAX = 8191;
    localparam int          DAC_MIN = -8192;

    typedef enum logic [1:0] {
        RAMP_IDLE = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_ON   = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

endpackage
`default_nettype wire

// File: rtl/ramp_envelope.sv
`default_nettype none
// ============================================================================
// ramp_envelope : start/stop amplitude envelope FSM, env in [0, ENV_ONE]
// Revision: 1.0
// ============================================================================
module ramp_envelope
    import dac_pkg::*;
(
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [15:0] step_i,
    output logic [15:0] env_o,
    output logic [1:0]  state_o,
    output logic        done_o
);

    ramp_state_t state_q, state_d;
    logic [15:0] env_q, env_d;
    logic        done_q, done_d;
    logic [16:0] w_up_sum;
    logic        w_step_zero;
    logic        w_go_up;

    assign w_up_sum    = {1'b0, env_q} + {1'b0, step_i};
    assign w_step_zero = (step_i == 16'd0);
    assign w_go_up     = start_i && !stop_i;

    // A zero step means "jump straight to the end value".
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        done_d  = 1'b0;
        case (state_q)
            RAMP_IDLE: begin
                env_d = '0;
                if (w_go_up) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (stop_i) begin
                    state_d = RAMP_DOWN;
                end else if (w_step_zero || (w_up_sum >= ENV_ONE)) begin
                    env_d   = 16'(ENV_ONE);
                    state_d = RAMP_ON;
                    done_d  = 1'b1;
                end else begin
                    env_d = w_up_sum[15:0];
                end
            end
            RAMP_ON: begin
                env_d = 16'(ENV_ONE);
                if (stop_i) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (w_go_up) begin
                    state_d = RAMP_UP;
                end else if (w_step_zero || (env_q <= step_i)) begin
                    env_d   = '0;
                    state_d = RAMP_IDLE;
                    done_d  = 1'b1;
                end else begin
                    env_d = env_q - step_i;
                end
            end
            default: state_d = RAMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= RAMP_IDLE;
            env_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            done_q  <= done_d;
        end
    end

    assign env_o   = env_q;
    assign state_o = state_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: rtl/dac_output_stage.sv
`default_nettype none
// ============================================================================
// dac_output_stage : gain/offset calibration, ramp envelope and saturation
//                    to a 14-bit DAC code, 4-cycle fixed latency
// Revision: 1.0
// ============================================================================
module dac_output_stage
    import dac_pkg::*;
(
    input  logic             clk,
    input  logic             aresetn,
    input  logic [IN_W-1:0]  signal_in,
    input  logic             signal_valid,
    input  logic [15:0]      cal_gain,
    input  logic [15:0]      cal_offset,
    input  logic             ramp_bypass,
    input  logic [15:0]      ramp_step,
    input  logic             ramp_start,
    input  logic             ramp_stop,
    input  logic             sat_clear,
    output logic [OUT_W-1:0] dac_out,
    output logic             dac_valid,
    output logic [1:0]       ramp_state,
    output logic             ramp_done,
    output logic [15:0]      sat_count
);

    // Stage widths sized so that no intermediate can wrap.
    localparam int P_W = IN_W + 16;
    localparam int C_W = P_W - GAIN_FRAC + 1;
    localparam int M_W = C_W + 17;
    localparam int E_W = M_W - ENV_FRAC;

    logic signed [P_W-1:0] p_q, p_d;
    logic signed [C_W-1:0] c_q, c_d;
    logic signed [E_W-1:0] e_q, e_d;
    logic signed [M_W-1:0] w_prod;
    logic signed [16:0]    w_env;
    logic [15:0]           w_env_raw;
    logic [OUT_W-1:0]      dac_q, dac_d;
    logic [3:0]            vld_q;
    logic [15:0]           sat_q, sat_d;
    logic                  w_clip_hi, w_clip_lo;

    ramp_envelope u_ramp (
        .clk     (clk),
        .aresetn (aresetn),
        .start_i (ramp_start),
        .stop_i  (ramp_stop),
        .step_i  (ramp_step),
        .env_o   (w_env_raw),
        .state_o (ramp_state),
        .done_o  (ramp_done)
    );

    assign p_d = signal_valid ? P_W'($signed(signal_in)) * P_W'($signed(cal_gain)) : '0;
    assign c_d = C_W'(p_q >>> GAIN_FRAC) + C_W'($signed(cal_offset));

    assign w_env  = ramp_bypass ? $signed(ENV_ONE) : $signed({1'b0, w_env_raw});
    assign w_prod = M_W'(c_q) * M_W'(w_env);
    assign e_d    = E_W'(w_prod >>> ENV_FRAC);

    assign w_clip_hi = (e_q > E_W'(DAC_MAX));
    assign w_clip_lo = (e_q < E_W'(DAC_MIN));
    assign dac_d     = w_clip_hi ? OUT_W'(DAC_MAX) :
                       w_clip_lo ? OUT_W'(DAC_MIN) : OUT_W'(e_q);

    // Clear wins over a same-cycle increment; the count sticks at full scale.
    always_comb begin
        sat_d = sat_q;
        if (sat_clear) begin
            sat_d = '0;
        end else if (vld_q[2] && (w_clip_hi || w_clip_lo) && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            p_q   <= '0;
            c_q   <= '0;
            e_q   <= '0;
            dac_q <= '0;
            vld_q <= '0;
            sat_q <= '0;
        end else begin
            p_q   <= p_d;
            c_q   <= c_d;
            e_q   <= e_d;
            dac_q <= dac_d;
            vld_q <= {vld_q[2:0], signal_valid};
            sat_q <= sat_d;
        end
    end

    assign dac_out   = dac_q;
    assign dac_valid = vld_q[3];
    assign sat_count = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_output_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dac_output_stage : directed bench with a cycle-level arithmetic model
// Revision: 1.0
// ============================================================================
module tb_dac_output_stage;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [18:0] signal_in = '0;
    logic        signal_valid = 1'b0;
    logic [15:0] cal_gain = 16'd16384;
    logic [15:0] cal_offset = '0;
    logic        ramp_bypass = 1'b1;
    logic [15:0] ramp_step = 16'd8192;
    logic        ramp_start = 1'b0;
    logic        ramp_stop = 1'b0;
    logic        sat_clear = 1'b0;
    logic [13:0] dac_out;
    logic        dac_valid;
    logic [1:0]  ramp_state;
    logic        ramp_done;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    dac_output_stage dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .signal_in    (signal_in),
        .signal_valid (signal_valid),
        .cal_gain     (cal_gain),
        .cal_offset   (cal_offset),
        .ramp_bypass  (ramp_bypass),
        .ramp_step    (ramp_step),
        .ramp_start   (ramp_start),
        .ramp_stop    (ramp_stop),
        .sat_clear    (sat_clear),
        .dac_out      (dac_out),
        .dac_valid    (dac_valid),
        .ramp_state   (ramp_state),
        .ramp_done    (ramp_done),
        .sat_count    (sat_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: history of per-cycle inputs; each output is recomputed from the
    // inputs that were present when the sample passed each stage.
    int     cyc = 0;
    longint h_in[8], h_gain[8], h_off[8], h_env[8];
    bit     h_vld[8], h_byp[8];
    int     m_state = 0;
    longint m_env = 0;
    bit     m_done = 1'b0;
    longint x_out = 0;
    bit     x_vld = 1'b0;
    int     x_sat = 0;

    always @(posedge clk or negedge aresetn) begin
        int     k, s;
        longint c, e, env, step;
        bit     clipped;
        if (!aresetn) begin
            m_state = 0;
            m_env   = 0;
            m_done  = 1'b0;
            x_out   = 0;
            x_vld   = 1'b0;
            x_sat   = 0;
            for (int i = 0; i < 8; i++) h_vld[i] = 1'b0;
        end else begin
            cyc++;
            k = cyc % 8;
            h_in[k]   = $signed(signal_in);
            h_vld[k]  = signal_valid;
            h_gain[k] = $signed(cal_gain);
            h_off[k]  = $signed(cal_offset);
            h_byp[k]  = ramp_bypass;
            h_env[k]  = m_env;

            s = (cyc + 5) % 8;
            clipped = 1'b0;
            x_vld = h_vld[s];
            if (h_vld[s]) begin
                c   = ((h_in[s] * h_gain[s]) >>> 14) + h_off[(cyc + 6) % 8];
                env = h_byp[(cyc + 7) % 8] ? 64'sd32768 : h_env[(cyc + 7) % 8];
                e   = (c * env) >>> 15;
                clipped = (e > 8191) || (e < -8192);
                x_out = (e > 8191) ? 8191 : (e < -8192) ? -8192 : e;
            end
            if (sat_clear) x_sat = 0;
            else if (clipped && x_sat < 65535) x_sat++;

            step = ramp_step;
            m_done = 1'b0;
            case (m_state)
                0: begin
                    m_env = 0;
                    if (ramp_start && !ramp_stop) m_state = 1;
                end
                1: if (ramp_stop) m_state = 3;
                   else begin
                       m_env = (step == 0) ? 32768 : m_env + step;
                       if (m_env >= 32768) begin m_env = 32768; m_state = 2; m_done = 1'b1; end
                   end
                2: begin
                    m_env = 32768;
                    if (ramp_stop) m_state = 3;
                end
                default: if (ramp_start && !ramp_stop) m_state = 1;
                   else begin
                       m_env = (step == 0) ? 0 : m_env - step;
                       if (m_env <= 0) begin m_env = 0; m_state = 0; m_done = 1'b1; end
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_dac_valid", dac_valid, x_vld);
            check("cyc_ramp_state", ramp_state, m_state);
            check("cyc_ramp_done", ramp_done, m_done);
            check("cyc_sat_count", sat_count, x_sat);
            if (x_vld) check("cyc_dac_out", $signed(dac_out), x_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic one_sample(input int val);
        signal_in = 19'(val);
        signal_valid = 1'b1;
        tick();
        signal_valid = 1'b0;
        signal_in = '0;
    endtask

    initial begin
        repeat (3) tick();
        aresetn = 1'b1;
        checking = 1'b1;
        check("rst_dac_out", $signed(dac_out), 0);
        check("rst_dac_valid", dac_valid, 0);
        check("rst_state", ramp_state, 0);
        check("rst_done", ramp_done, 0);
        check("rst_sat", sat_count, 0);

        // unity gain, bypassed envelope, latency
        one_sample(1000);
        tick(); tick();
        check("t1_valid_early", dac_valid, 0);
        tick();
        check("t1_dac_out", $signed(dac_out), 1000);
        check("t1_valid", dac_valid, 1);
        tick();
        check("t1_valid_drop", dac_valid, 0);

        // positive and negative clipping, sat_clear priority
        signal_valid = 1'b1;
        signal_in = 19'(20000); tick();
        signal_in = 19'(-20000); tick();
        signal_valid = 1'b0; signal_in = '0;
        tick(); tick();
        check("t2_clip_hi", $signed(dac_out), 8191);
        tick();
        check("t2_clip_lo", $signed(dac_out), -8192);
        check("t2_sat2", sat_count, 2);
        one_sample(20000);
        tick(); tick();
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("t2_clear_out", $signed(dac_out), 8191);
        check("t2_clear_sat", sat_count, 0);

        // calibration: half gain with negative offset, negative gain, offset clip
        cal_gain = 16'd8192; cal_offset = 16'(-5);
        one_sample(101);
        tick(); tick(); tick();
        check("t3_gain_half", $signed(dac_out), 45);
        cal_gain = 16'(-16384); cal_offset = 16'd100;
        one_sample(300);
        tick(); tick(); tick();
        check("t3_gain_neg", $signed(dac_out), -200);
        cal_gain = 16'd16384; cal_offset = 16'd20000;
        one_sample(0);
        tick(); tick(); tick();
        check("t3_offset_clip", $signed(dac_out), 8191);
        check("t3_offset_sat", sat_count, 1);
        cal_offset = '0;

        // ramp up through the envelope
        ramp_bypass = 1'b0;
        signal_in = 19'(4000); signal_valid = 1'b1;
        repeat (4) tick();
        check("t4_env0_out", $signed(dac_out), 0);
        ramp_start = 1'b1; tick(); ramp_start = 1'b0;
        check("t4_state_up", ramp_state, 1);
        tick(); tick(); tick();
        check("t4_out_1000", $signed(dac_out), 1000);
        tick();
        check("t4_out_2000", $signed(dac_out), 2000);
        check("t4_state_on", ramp_state, 2);
        check("t4_done", ramp_done, 1);
        tick();
        check("t4_out_3000", $signed(dac_out), 3000);
        check("t4_done_low", ramp_done, 0);
        tick();
        check("t4_out_4000", $signed(dac_out), 4000);

        // ramp down from ON, then stop mid-ramp
        ramp_stop = 1'b1; tick(); ramp_stop = 1'b0;
        check("t5_state_down", ramp_state, 3);
        repeat (4) tick();
        check("t5_idle", ramp_state, 0);
        check("t5_idle_done", ramp_done, 1);
        ramp_start = 1'b1; tick(); ramp_start = 1'b0;
        tick(); tick();
        ramp_stop = 1'b1; tick(); ramp_stop = 1'b0;
        check("t5_mid_down", ramp_state, 3);
        tick();
        check("t5_mid_down2", ramp_state, 3);
        check("t5_mid_nodone", ramp_done, 0);
        tick();
        check("t5_mid_idle", ramp_state, 0);
        check("t5_mid_done", ramp_done, 1);
        ramp_start = 1'b1; ramp_stop = 1'b1;
        tick(); tick();
        check("t5_both_idle", ramp_state, 0);
        ramp_start = 1'b0; ramp_stop = 1'b0;

        // asynchronous reset while ON
        ramp_start = 1'b1; tick(); ramp_start = 1'b0;
        repeat (4) tick();
        check("t6_on", ramp_state, 2);
        aresetn = 1'b0;
        #2;
        check("t6_rst_out", $signed(dac_out), 0);
        check("t6_rst_valid", dac_valid, 0);
        check("t6_rst_state", ramp_state, 0);
        check("t6_rst_sat", sat_count, 0);
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_valid_held", dac_valid, 0);
        end
        tick();
        check("t6_valid_back", dac_valid, 1);
        check("t6_out_idle", $signed(dac_out), 0);

        signal_valid = 1'b0;
        repeat (3) tick();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
